counter_seq_ctrl: RTL and testbench
===================================

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 SHALL have parameter MOD, default 12, counter modulus; legal counter values are 0..MOD-1.
REQ-002 SHALL have parameter W, default 4, width of counter value and step count.
REQ-003 SHALL have port clk, input, 1, the only clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1, command request.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid and cmd_ready are high on the same edge.
REQ-007 SHALL have port cmd_op, input, 2, operation: 00 LOAD, 01 UP, 10 DOWN, 11 CLEAR.
REQ-008 SHALL have port cmd_arg, input, W, load value (LOAD) or step count (UP/DOWN); ignored for CLEAR.
REQ-009 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port err, output, 1, valid with done; marks a rejected command.
REQ-011 SHALL have port result, output, W, counter value at done.
REQ-012 SHALL have port wraps, output, 2, number of modulus wrap events during the completed command, valid with done.
REQ-013 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-014 SHALL have port cnt_reset, output, 1, drives the counter's reset.
REQ-015 SHALL have port cnt_load, output, 1, counter loads cnt_data_in on the next edge when high.
REQ-016 SHALL have port cnt_mode, output, 1, counter direction when not loading: 1 up, 0 down.
REQ-017 SHALL have port cnt_data_in, output, W, counter load value.
REQ-018 SHALL have port cnt_data_out, input, W, counter current value.

Function
REQ-019 SHALL implement FSM states IDLE, EXEC, COUNT, DONE.
REQ-020 SHALL assert cmd_ready only in IDLE.
REQ-021 SHALL, in IDLE, hold the counter: cnt_load=1, cnt_data_in=cnt_data_out.
REQ-022 SHALL, on acceptance, register cmd_op and cmd_arg; the inputs are don't-care afterwards.
REQ-023 SHALL, for LOAD with cmd_arg<=MOD-1, go IDLE->EXEC->DONE: EXEC drives cnt_load=1 and cnt_data_in=arg for one cycle; done is 2 cycles after acceptance, with result=arg and err=0.
REQ-024 SHALL, for LOAD with cmd_arg>MOD-1, go IDLE->DONE with err=1, result=unchanged counter value, and the counter untouched.
REQ-025 SHALL, for CLEAR, go IDLE->EXEC->DONE with cnt_reset=1 for the EXEC cycle only; result=0 and err=0.
REQ-026 SHALL, for UP/DOWN with arg=n>0, stay in COUNT exactly n cycles with cnt_load=0 and cnt_mode per op, then enter DONE; done is n+1 cycles after acceptance.
REQ-027 SHALL, for UP/DOWN with n=0, go IDLE->DONE directly with result=current value, wraps=0 and err=0.
REQ-028 SHALL count a wrap on each COUNT cycle where (UP and cnt_data_out==MOD-1) or (DOWN and cnt_data_out==0); the wrap counter clears on acceptance and saturates at 3.
REQ-029 SHALL, in DONE, pulse done for one cycle, present result=cnt_data_out, hold the counter as in IDLE, then return to IDLE.
REQ-030 SHALL keep result, err and wraps stable from done until the next done.
REQ-031 SHALL NOT accept a command in DONE; the earliest next acceptance is the cycle after done.
REQ-032 SHALL drive cnt_reset = reset OR (state==EXEC AND op==CLEAR).

Reset
REQ-033 SHALL, when reset is high at an edge, enter IDLE regardless of state; an in-flight command is aborted and no done is issued.
REQ-034 SHALL reset outputs as follows: done=0, err=0, result=0, wraps=0, busy=0; cmd_ready=1 from the first cycle after reset.

Structure
REQ-035 SHALL take the op encoding enum, the state enum, MOD and W from shared package counter_ctrl_pkg.
REQ-036 SHALL be a single module with no sub-modules; the step down-counter and the wrap counter are inline registers.

Verification
REQ-037 SHALL cover: reset, then LOAD 7 -> done 2 cycles later, result=7, err=0, wraps=0.
REQ-038 SHALL cover: counter at 10, UP 5 -> done 6 cycles later, result=3, wraps=1.
REQ-039 SHALL cover: counter at 1, DOWN 15 -> result=10, wraps=2.
REQ-040 SHALL cover: LOAD 13 -> done next cycle, err=1, counter value unchanged.
REQ-041 SHALL cover: reset asserted mid-UP 9 -> no done, IDLE and cmd_ready=1 afterwards, counter=0.
REQ-042 SHALL cover: back-to-back CLEAR then UP 0 with cmd_valid held high -> second command accepted the cycle after the first done, result=0.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter sequencing controller: command opcodes,
// FSM states and the default counter geometry.
package counter_ctrl_pkg;

    localparam int MOD = 12;
    localparam int W   = 4;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_UP    = 2'b01,
        OP_DOWN  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_EXEC  = 2'b01,
        S_COUNT = 2'b10,
        S_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/counter_seq_ctrl.sv
// Sequences LOAD/UP/DOWN/CLEAR commands onto an external modulus counter and
// reports the final value, a reject flag and the number of wraps seen.
module counter_seq_ctrl #(
    parameter int MOD = counter_ctrl_pkg::MOD,
    parameter int W   = counter_ctrl_pkg::W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_arg,
    output logic         done,
    output logic         err,
    output logic [W-1:0] result,
    output logic [1:0]   wraps,
    output logic         busy,
    output logic         cnt_reset,
    output logic         cnt_load,
    output logic         cnt_mode,
    output logic [W-1:0] cnt_data_in,
    input  logic [W-1:0] cnt_data_out
);

    typedef counter_ctrl_pkg::op_e    op_t;
    typedef counter_ctrl_pkg::state_e state_t;

    localparam logic [W-1:0] MAXV = W'(MOD - 1);

    state_t       state, state_nx;
    op_t          op_q;
    logic [W-1:0] arg_q;
    logic [W-1:0] steps;
    logic [1:0]   wcnt;
    logic         rej;
    logic [W-1:0] result_q;
    logic         err_q;
    logic [1:0]   wraps_q;
    logic         accept;
    logic         cmd_rej;
    logic         wrap_hit;

    assign accept   = cmd_valid && cmd_ready;
    assign cmd_rej  = (op_t'(cmd_op) == counter_ctrl_pkg::OP_LOAD) && (cmd_arg > MAXV);
    assign wrap_hit = ((op_q == counter_ctrl_pkg::OP_UP)   && (cnt_data_out == MAXV)) ||
                      ((op_q == counter_ctrl_pkg::OP_DOWN) && (cnt_data_out == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= counter_ctrl_pkg::S_IDLE;
            op_q     <= counter_ctrl_pkg::OP_LOAD;
            arg_q    <= '0;
            steps    <= '0;
            wcnt     <= '0;
            rej      <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
            wraps_q  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q  <= op_t'(cmd_op);
                arg_q <= cmd_arg;
                steps <= cmd_arg;
                wcnt  <= '0;
                rej   <= cmd_rej;
            end
            if (state == counter_ctrl_pkg::S_COUNT) begin
                steps <= steps - 1'b1;
                if (wrap_hit && wcnt != 2'd3)
                    wcnt <= wcnt + 2'd1;
            end
            // Latch the completion report so it holds until the next done.
            if (state == counter_ctrl_pkg::S_DONE) begin
                result_q <= cnt_data_out;
                err_q    <= rej;
                wraps_q  <= wcnt;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_load    = 1'b1;
        cnt_data_in = cnt_data_out;
        cnt_mode    = (op_q == counter_ctrl_pkg::OP_UP);
        case (state)
            counter_ctrl_pkg::S_IDLE: begin
                if (accept) begin
                    case (op_t'(cmd_op))
                        counter_ctrl_pkg::OP_LOAD:
                            state_nx = cmd_rej ? counter_ctrl_pkg::S_DONE : counter_ctrl_pkg::S_EXEC;
                        counter_ctrl_pkg::OP_CLEAR:
                            state_nx = counter_ctrl_pkg::S_EXEC;
                        default:
                            state_nx = (cmd_arg == '0) ? counter_ctrl_pkg::S_DONE : counter_ctrl_pkg::S_COUNT;
                    endcase
                end
            end
            counter_ctrl_pkg::S_EXEC: begin
                // CLEAR relies on cnt_reset, so load stays off for it.
                cnt_load    = (op_q == counter_ctrl_pkg::OP_LOAD);
                cnt_data_in = arg_q;
                state_nx    = counter_ctrl_pkg::S_DONE;
            end
            counter_ctrl_pkg::S_COUNT: begin
                cnt_load = 1'b0;
                if (steps == W'(1))
                    state_nx = counter_ctrl_pkg::S_DONE;
            end
            default: state_nx = counter_ctrl_pkg::S_IDLE;
        endcase
    end

    assign cnt_reset = reset || ((state == counter_ctrl_pkg::S_EXEC) && (op_q == counter_ctrl_pkg::OP_CLEAR));
    assign cmd_ready = (state == counter_ctrl_pkg::S_IDLE);
    assign busy      = (state != counter_ctrl_pkg::S_IDLE);
    assign done      = (state == counter_ctrl_pkg::S_DONE);
    assign result    = done ? cnt_data_out : result_q;
    assign err       = done ? rej  : err_q;
    assign wraps     = done ? wcnt : wraps_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Drives the controller against a simple modulus counter and checks each
// command against an arithmetic model of the expected outcome.
module tb_counter_seq_ctrl;
    import counter_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_arg;
    logic         done, err, busy;
    logic [W-1:0] result;
    logic [1:0]   wraps;
    logic         cnt_reset, cnt_load, cnt_mode;
    logic [W-1:0] cnt_data_in;
    logic [W-1:0] cv;

    int checks = 0;
    int errors = 0;
    int mv = 0;

    always #5 clk = ~clk;

    counter_seq_ctrl #(.MOD(MOD), .W(W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .done(done), .err(err), .result(result),
        .wraps(wraps), .busy(busy), .cnt_reset(cnt_reset), .cnt_load(cnt_load),
        .cnt_mode(cnt_mode), .cnt_data_in(cnt_data_in), .cnt_data_out(cv)
    );

    // External counter the controller steers.
    always @(posedge clk) begin
        if (cnt_reset)     cv <= '0;
        else if (cnt_load) cv <= cnt_data_in;
        else if (cnt_mode) cv <= (cv == W'(MOD - 1)) ? '0 : cv + 1'b1;
        else               cv <= (cv == '0) ? W'(MOD - 1) : cv - 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input int op, input int arg, input string tag);
        int res, wr, er, lat, g, m;
        wr = 0; er = 0;
        case (op)
            0: begin
                if (arg <= MOD - 1) begin res = arg; lat = 2; end
                else begin res = mv; lat = 1; er = 1; end
            end
            1: begin
                res = (mv + arg) % MOD;
                m = (mv + arg) / MOD;
                wr = (m > 3) ? 3 : m;
                lat = (arg == 0) ? 1 : arg + 1;
            end
            2: begin
                res = (((mv - arg) % MOD) + MOD) % MOD;
                m = (arg > mv) ? (arg - mv - 1) / MOD + 1 : 0;
                wr = (m > 3) ? 3 : m;
                lat = (arg == 0) ? 1 : arg + 1;
            end
            default: begin res = 0; lat = 2; end
        endcase
        g = 0;
        while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
        chk({tag, " ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = 2'(op); cmd_arg = W'(arg);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_arg = W'($urandom);
        g = 1;
        while (!done && g < 40) begin @(negedge clk); g++; end
        chk({tag, " latency"}, g, lat);
        chk({tag, " result"}, result, res);
        chk({tag, " err"}, err, er);
        chk({tag, " wraps"}, wraps, wr);
        chk({tag, " counter"}, cv, res);
        mv = res;
        @(negedge clk);
        chk({tag, " held"}, {done, err, wraps, result}, {1'b0, er[0], wr[1:0], res[W-1:0]});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst outputs", {done, err, wraps, result, busy}, '0);
        chk("rst ready", cmd_ready, 1);
        chk("rst counter", cv, 0);
        mv = 0;

        run_cmd(0, 7, "load7");
        run_cmd(0, 10, "load10");
        run_cmd(1, 5, "up5");
        run_cmd(0, 1, "load1");
        run_cmd(2, 15, "down15");
        run_cmd(0, 13, "load13");
        run_cmd(0, 11, "load11");
        run_cmd(1, 0, "up0");
        run_cmd(2, 0, "down0");
        run_cmd(1, 15, "up15");

        // Reset in the middle of a long UP.
        cmd_valid = 1'b1; cmd_op = 2'(1); cmd_arg = W'(9);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        g = 0;
        repeat (3) begin if (done) g++; @(negedge clk); end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        chk("abort ready", {cmd_ready, busy}, 2'b10);
        chk("abort counter", cv, 0);
        chk("abort result", result, 0);
        repeat (4) begin if (done) g++; @(negedge clk); end
        chk("abort nodone", g, 0);
        mv = 0;

        // CLEAR then UP 0 with valid held high throughout.
        run_cmd(0, 5, "pre");
        cmd_valid = 1'b1; cmd_op = 2'(3); cmd_arg = '0;
        @(posedge clk); @(negedge clk);
        g = 1;
        while (!done && g < 40) begin @(negedge clk); g++; end
        chk("b2b clear lat", g, 2);
        chk("b2b clear res", result, 0);
        cmd_op = 2'(1); cmd_arg = '0;
        @(negedge clk);
        chk("b2b gap", {done, cmd_ready}, 2'b01);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b up0", {done, err, wraps, result}, {1'b1, 1'b0, 2'd0, W'(0)});
        mv = 0;
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), "rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
